dsp_proj: RTL and testbench
===========================

# dsp_proj

Single-slice DSP48A1-style multiply-accumulate block with configurable pipeline registers:
- 18-bit pre-adder/subtractor (D ± B);
- 18×18 multiplier;
- 48-bit post-adder/subtractor with X/Z operand muxes and carry logic.

It sits in the datapath as a reusable arithmetic primitive and can be cascaded through BCOUT/PCOUT/carryout.

## Interface
Parameters:
- A0REG, B0REG, default 0: first-stage A/B register enable (1 = registered, 0 = bypass).
- A1REG, B1REG, CREG, DREG, MREG, PREG, CARRYINREG, CARRYOUTREG, OPMODEREG, default 1: same meaning for each named stage.
- CARRYINSEL, default "OPMODE5":
  - "OPMODE5": carry source is opmode[5].
  - "CARRYIN": carry source is the carryin port.
  - Any other value: carry 0.
- B_INPUT, default "DIRECT":
  - "DIRECT": B source is the B port.
  - "CASCADE": B source is BCIN.
  - Any other value: 0.

Ports:
- clk  in  1  single clock; all registers rise-edge.
- RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE  in  1 each  per-stage reset; reset is asynchronous and active-high.
- CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE  in  1 each  per-stage clock enable, active-high.
- A, B, D, BCIN  in  18 each  data operands / B cascade input.
- C, PCIN  in  48 each  post-adder operand / P cascade input.
- carryin  in  1  external carry.
- opmode  in  8  operation select.
- M  out  36  multiplier register output.
- P  out  48  result.
- PCOUT  out  48  equals P.
- BCOUT  out  18  B1-stage output.
- carryout  out  1  post-adder carry.
- carryoutF  out  1  equals carryout.

## Operation
Every stage is a register with its own reset/CE, or a wire when its parameter is 0. Reset beats CE. All registers reset to 0.

Datapath:
- A path: A → A0 → A1.
- B path: B/BCIN → B0.
- C path: C → CREG.
- D path: D → DREG.
- opmode → OPMODEREG; all opmode bits below refer to the registered opmode.

Pre-adder, 18-bit, wraps modulo 2^18:
- opmode[6]=0: D+B0.
- opmode[6]=1: D−B0.

B1 input:
- opmode[4]=1: pre-adder result.
- opmode[4]=0: B0.

Multiplier:
- M = B1 × A1, unsigned 36-bit, into MREG.
- Zero-extended to 48 bits for the X mux.

X mux, selected by opmode[1:0]:
- 0: 0
- 1: M
- 2: P
- 3: {D[11:0], A1, B1}

Z mux, selected by opmode[3:2]:
- 0: 0
- 1: PCIN
- 2: P
- 3: C

Carry:
- Carry source is chosen per CARRYINSEL.
- It passes through the CARRYINREG stage (RSTCARRYIN/CECARRYIN) to give CIN.

Post-adder, 49-bit result:
- opmode[7]=0: Z + X + CIN.
- opmode[7]=1: Z − (X + CIN).
- Bits [47:0] go to PREG; bit 48 goes to CARRYOUTREG (reset/enable by RSTCARRYIN/CECARRYIN).
- In subtract mode, bit 48 is the borrow.
- Overflow wraps modulo 2^48.

Outputs:
- M = MREG output.
- P = PREG output; PCOUT = P.
- BCOUT = B1 output.
- carryout = carryoutF = CARRYOUTREG output.

## Timing
Defaults, counted in rising edges after the input is applied with CE=1:
- A/B → BCOUT: 1. A/B → M: 2. A/B → P: 3.
- D → pre-adder → BCOUT: 2 (D goes through DREG, B0 is bypassed, so D lags B by one cycle). D → P: 4.
- C → P: 2.
- opmode change takes effect 1 cycle later (OPMODEREG).
- carryout is aligned with P.

Resets:
- Asserting any RST* clears its stage immediately, without waiting for clk.
- During reset all outputs are 0.
- Deasserting a reset mid-operation restarts that stage from 0; downstream stages flush within the remaining latency.

Clock enables:
- CE low holds the stage value.
- Feedback paths (X=P or Z=P) accumulate once per enabled PREG edge.

## Test plan
- Reset all stages 5 cycles, then release with zero inputs → P=0, M=0, BCOUT=0, carryout=0.
- A=10, B=5, opmode=0x01, hold 6 cycles → M=50, P=50, BCOUT=5.
- A=3, B=4, D=6, opmode=0x11 → BCOUT=10, M=30, P=30.
- A=5, B=3, D=8, opmode=0x51 → BCOUT=5, M=25, P=25.
- C=100, A=2, B=3, opmode=0x0D, then opmode=0x2D:
  - 0x0D: P=106.
  - 0x2D (carry 1): P=107.
  - Switch to 0x09 (Z=P): P accumulates +6 per cycle.
- C=0, X=M=1, opmode=0x8D → P=2^48−1, carryout=1 (borrow). Then assert RSTP mid-run → P=0 immediately; hold CEP=0 after release → P stays 0.

Source files
------------

// File: rtl/dsp_proj.sv
// dsp_proj: single-slice multiply-accumulate primitive in the DSP48A1 mould.
// The datapath is an 18-bit pre-adder (D +/- B), an 18x18 unsigned multiplier,
// and a 48-bit post-adder/subtractor with X/Z operand muxes and carry.
// Every pipeline stage can be a register (own async reset and clock enable)
// or a plain wire, chosen by its parameter. Cascade ports BCOUT/PCOUT allow
// chaining slices. There is no handshake: data moves every enabled edge.
module dsp_proj #(
    parameter int    A0REG       = 0,
    parameter int    B0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT"
) (
    input  logic        clk,
    input  logic        RSTA,
    input  logic        RSTB,
    input  logic        RSTC,
    input  logic        RSTD,
    input  logic        RSTM,
    input  logic        RSTP,
    input  logic        RSTCARRYIN,
    input  logic        RSTOPMODE,
    input  logic        CEA,
    input  logic        CEB,
    input  logic        CEC,
    input  logic        CED,
    input  logic        CEM,
    input  logic        CEP,
    input  logic        CECARRYIN,
    input  logic        CEOPMODE,
    input  logic [17:0] A,
    input  logic [17:0] B,
    input  logic [17:0] D,
    input  logic [17:0] BCIN,
    input  logic [47:0] C,
    input  logic [47:0] PCIN,
    input  logic        carryin,
    input  logic [7:0]  opmode,
    output logic [35:0] M,
    output logic [47:0] P,
    output logic [47:0] PCOUT,
    output logic [17:0] BCOUT,
    output logic        carryout,
    output logic        carryoutF
);

    // Source selections resolved at elaboration time.
    localparam logic B_FROM_PORT    = (B_INPUT == "DIRECT");
    localparam logic B_FROM_CASCADE = (B_INPUT == "CASCADE");
    localparam logic CIN_FROM_OPM   = (CARRYINSEL == "OPMODE5");
    localparam logic CIN_FROM_PORT  = (CARRYINSEL == "CARRYIN");

    // Stage register state (_q) and the stage outputs after the bypass mux.
    logic [17:0] a0_q, a1_q, b0_q, b1_q, d_q;
    logic [47:0] c_q, p_q;
    logic [35:0] m_q;
    logic [7:0]  opm_q;
    logic        cin_q, cout_q;

    logic [17:0] a0, a1, b0, b1, d;
    logic [47:0] c;
    logic [35:0] m;
    logic [7:0]  opm;
    logic        cin;

    // Next-state values of the computing stages.
    logic [17:0] b_src;
    logic [17:0] preadd_d;
    logic [17:0] b1_d;
    logic [35:0] m_d;
    logic        carry_src;
    logic [47:0] x_mux;
    logic [47:0] z_mux;
    logic [48:0] post_d;

    // B operand source: direct port, cascade input, or tied off.
    always_comb begin
        b_src = '0;
        if (B_FROM_PORT) begin
            b_src = B;
        end else if (B_FROM_CASCADE) begin
            b_src = BCIN;
        end
    end

    // A0 stage.
    always_ff @(posedge clk or posedge RSTA) begin
        if (RSTA) begin
            a0_q <= '0;
        end else if (CEA) begin
            a0_q <= A;
        end
    end
    assign a0 = (A0REG != 0) ? a0_q : A;

    // A1 stage, shares reset/enable with A0.
    always_ff @(posedge clk or posedge RSTA) begin
        if (RSTA) begin
            a1_q <= '0;
        end else if (CEA) begin
            a1_q <= a0;
        end
    end
    assign a1 = (A1REG != 0) ? a1_q : a0;

    // B0 stage.
    always_ff @(posedge clk or posedge RSTB) begin
        if (RSTB) begin
            b0_q <= '0;
        end else if (CEB) begin
            b0_q <= b_src;
        end
    end
    assign b0 = (B0REG != 0) ? b0_q : b_src;

    // D stage.
    always_ff @(posedge clk or posedge RSTD) begin
        if (RSTD) begin
            d_q <= '0;
        end else if (CED) begin
            d_q <= D;
        end
    end
    assign d = (DREG != 0) ? d_q : D;

    // C stage.
    always_ff @(posedge clk or posedge RSTC) begin
        if (RSTC) begin
            c_q <= '0;
        end else if (CEC) begin
            c_q <= C;
        end
    end
    assign c = (CREG != 0) ? c_q : C;

    // Opmode stage; every opmode decode below uses this registered copy.
    always_ff @(posedge clk or posedge RSTOPMODE) begin
        if (RSTOPMODE) begin
            opm_q <= '0;
        end else if (CEOPMODE) begin
            opm_q <= opmode;
        end
    end
    assign opm = (OPMODEREG != 0) ? opm_q : opmode;

    // Pre-adder (wraps at 18 bits) and B1 input select.
    always_comb begin
        preadd_d = opm[6] ? (d - b0) : (d + b0);
        b1_d     = opm[4] ? preadd_d : b0;
    end

    // B1 stage, shares reset/enable with B0; its output is also BCOUT.
    always_ff @(posedge clk or posedge RSTB) begin
        if (RSTB) begin
            b1_q <= '0;
        end else if (CEB) begin
            b1_q <= b1_d;
        end
    end
    assign b1 = (B1REG != 0) ? b1_q : b1_d;

    // Unsigned 18x18 multiplier.
    always_comb begin
        m_d = 36'(a1) * 36'(b1);
    end

    // M stage.
    always_ff @(posedge clk or posedge RSTM) begin
        if (RSTM) begin
            m_q <= '0;
        end else if (CEM) begin
            m_q <= m_d;
        end
    end
    assign m = (MREG != 0) ? m_q : m_d;

    // Carry source select.
    always_comb begin
        carry_src = 1'b0;
        if (CIN_FROM_OPM) begin
            carry_src = opm[5];
        end else if (CIN_FROM_PORT) begin
            carry_src = carryin;
        end
    end

    // Carry-in stage.
    always_ff @(posedge clk or posedge RSTCARRYIN) begin
        if (RSTCARRYIN) begin
            cin_q <= 1'b0;
        end else if (CECARRYIN) begin
            cin_q <= carry_src;
        end
    end
    assign cin = (CARRYINREG != 0) ? cin_q : carry_src;

    // X and Z operand muxes; P feedback gives accumulate behaviour.
    always_comb begin
        x_mux = '0;
        case (opm[1:0])
            2'd0:    x_mux = '0;
            2'd1:    x_mux = {12'd0, m};
            2'd2:    x_mux = P;
            default: x_mux = {d[11:0], a1, b1};
        endcase
        z_mux = '0;
        case (opm[3:2])
            2'd0:    z_mux = '0;
            2'd1:    z_mux = PCIN;
            2'd2:    z_mux = P;
            default: z_mux = c;
        endcase
    end

    // Post-adder; bit 48 is the carry when adding, the borrow when subtracting.
    always_comb begin
        if (opm[7]) begin
            post_d = {1'b0, z_mux} - ({1'b0, x_mux} + {48'd0, cin});
        end else begin
            post_d = {1'b0, z_mux} + {1'b0, x_mux} + {48'd0, cin};
        end
    end

    // P stage.
    always_ff @(posedge clk or posedge RSTP) begin
        if (RSTP) begin
            p_q <= '0;
        end else if (CEP) begin
            p_q <= post_d[47:0];
        end
    end
    assign P = (PREG != 0) ? p_q : post_d[47:0];

    // Carry-out stage, controlled by the carry-in reset/enable pair.
    always_ff @(posedge clk or posedge RSTCARRYIN) begin
        if (RSTCARRYIN) begin
            cout_q <= 1'b0;
        end else if (CECARRYIN) begin
            cout_q <= post_d[48];
        end
    end
    assign carryout = (CARRYOUTREG != 0) ? cout_q : post_d[48];

    assign M         = m;
    assign PCOUT     = P;
    assign BCOUT     = b1;
    assign carryoutF = carryout;

endmodule

// File: tb/tb_dsp_proj.sv
// Directed and randomized checks of dsp_proj with default parameters.
module tb_dsp_proj;

    logic        clk = 1'b0;
    logic        RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE;
    logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
    logic [17:0] A, B, D, BCIN;
    logic [47:0] C, PCIN;
    logic        carryin;
    logic [7:0]  opmode;
    logic [35:0] M;
    logic [47:0] P, PCOUT;
    logic [17:0] BCOUT;
    logic        carryout, carryoutF;

    int n_cmp  = 0;
    int n_fail = 0;

    dsp_proj dut (
        .clk(clk),
        .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD),
        .RSTM(RSTM), .RSTP(RSTP), .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
        .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED),
        .CEM(CEM), .CEP(CEP), .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
        .A(A), .B(B), .D(D), .BCIN(BCIN),
        .C(C), .PCIN(PCIN),
        .carryin(carryin),
        .opmode(opmode),
        .M(M), .P(P), .PCOUT(PCOUT), .BCOUT(BCOUT),
        .carryout(carryout), .carryoutF(carryoutF)
    );

    // clock
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steady-state reference: the value each output settles to when the
    // inputs are held long enough to fill the pipeline (no P feedback).
    typedef struct {
        logic [63:0] bcout;
        logic [63:0] m;
        logic [63:0] p;
        logic [63:0] cout;
    } ref_t;

    function automatic ref_t ref_model(input logic [63:0] a, b, d, c, pcin,
                                       input logic [7:0] op);
        ref_t        r;
        logic [63:0] b1, x, z, cy, sum;
        logic [63:0] mask18 = 64'h3FFFF;
        logic [63:0] mask49 = (64'd1 << 49) - 64'd1;
        if (op[4]) b1 = (op[6] ? (d - b) : (d + b)) & mask18;
        else       b1 = b;
        r.bcout = b1;
        r.m     = a * b1;
        case (op[1:0])
            2'd0:    x = 0;
            2'd1:    x = r.m;
            default: x = ((d & 64'hFFF) << 36) | (a << 18) | b1;
        endcase
        case (op[3:2])
            2'd0:    z = 0;
            2'd1:    z = pcin;
            default: z = c;
        endcase
        cy  = {63'd0, op[5]};
        sum = op[7] ? ((z - x - cy) & mask49) : ((z + x + cy) & mask49);
        r.p    = sum & 64'hFFFF_FFFF_FFFF;
        r.cout = sum >> 48;
        return r;
    endfunction

    initial begin
        logic [63:0] p_base;
        logic [63:0] r64;
        ref_t        e;
        int          xs, zs;

        RSTA = 1; RSTB = 1; RSTC = 1; RSTD = 1;
        RSTM = 1; RSTP = 1; RSTCARRYIN = 1; RSTOPMODE = 1;
        CEA = 1; CEB = 1; CEC = 1; CED = 1;
        CEM = 1; CEP = 1; CECARRYIN = 1; CEOPMODE = 1;
        A = 0; B = 0; D = 0; BCIN = 0; C = 0; PCIN = 0;
        carryin = 0; opmode = 0;

        // reset all stages, outputs 0 during and after reset
        tick(5);
        check("rst_hold_p", P, 0);
        check("rst_hold_m", M, 0);
        RSTA = 0; RSTB = 0; RSTC = 0; RSTD = 0;
        RSTM = 0; RSTP = 0; RSTCARRYIN = 0; RSTOPMODE = 0;
        tick(2);
        check("rst_p", P, 0);
        check("rst_m", M, 0);
        check("rst_bcout", BCOUT, 0);
        check("rst_cout", carryout, 0);

        // simple multiply
        A = 10; B = 5; opmode = 8'h01;
        tick(6);
        check("mul_m", M, 50);
        check("mul_p", P, 50);
        check("mul_bcout", BCOUT, 5);
        check("mul_pcout", PCOUT, 50);

        // latency: B->BCOUT 1, B->M 2, B->P 3 edges
        B = 7;
        tick(1);
        check("lat1_bcout", BCOUT, 7);
        check("lat1_m_old", M, 50);
        tick(1);
        check("lat2_m", M, 70);
        check("lat2_p_old", P, 50);
        tick(1);
        check("lat3_p", P, 70);

        // pre-adder add
        A = 3; B = 4; D = 6; opmode = 8'h11;
        tick(6);
        check("preadd_bcout", BCOUT, 10);
        check("preadd_m", M, 30);
        check("preadd_p", P, 30);

        // pre-adder subtract
        A = 5; B = 3; D = 8; opmode = 8'h51;
        tick(6);
        check("presub_bcout", BCOUT, 5);
        check("presub_m", M, 25);
        check("presub_p", P, 25);

        // C + M, then with carry
        C = 100; A = 2; B = 3; D = 0; opmode = 8'h0D;
        tick(6);
        check("cadd_p", P, 106);
        opmode = 8'h2D;
        tick(6);
        check("cadd_cin_p", P, 107);
        check("cadd_cin_cout", carryout, 0);

        // accumulate P += M each enabled edge (after carry pipe drains)
        opmode = 8'h09;
        tick(3);
        p_base = 64'(P);
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            check("acc_step", P, (p_base + 64'(6 * k)) & 64'hFFFF_FFFF_FFFF);
        end
        p_base = 64'(P);
        CEP = 0;
        tick(2);
        check("acc_hold", P, p_base);
        CEP = 1;
        tick(1);
        check("acc_resume", P, p_base + 6);

        // subtract 0 - 1: wrap and borrow
        C = 0; A = 1; B = 1; opmode = 8'h8D;
        tick(6);
        check("sub_p", P, 64'hFFFF_FFFF_FFFF);
        check("sub_cout", carryout, 1);
        check("sub_coutf", carryoutF, 1);

        // asynchronous RSTP between edges, then hold with CEP low
        #2;
        RSTP = 1;
        #1;
        check("rstp_async_p", P, 0);
        check("rstp_async_m", M, 1);
        tick(1);
        RSTP = 0; CEP = 0;
        tick(3);
        check("rstp_cep0_p", P, 0);
        CEP = 1;

        // clock-enable hold on the A path
        A = 9; B = 2; opmode = 8'h01;
        tick(6);
        CEA = 0; A = 100;
        tick(4);
        check("cea_hold_m", M, 18);
        CEA = 1;
        tick(4);
        check("cea_resume_m", M, 200);

        // randomized steady-state operations against the reference model
        for (int i = 0; i < 24; i++) begin
            A = 18'($urandom_range(0, 262143));
            B = 18'($urandom_range(0, 262143));
            D = 18'($urandom_range(0, 262143));
            r64 = {$urandom(), $urandom()};
            C = r64[47:0];
            r64 = {$urandom(), $urandom()};
            PCIN = r64[47:0];
            xs = $urandom_range(0, 2);
            zs = $urandom_range(0, 2);
            if (xs == 2) xs = 3;
            if (zs == 2) zs = 3;
            opmode = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      2'(zs), 2'(xs)};
            e = ref_model(64'(A), 64'(B), 64'(D), 64'(C), 64'(PCIN), opmode);
            tick(6);
            check("rnd_bcout", BCOUT, e.bcout);
            check("rnd_m", M, e.m);
            check("rnd_p", P, e.p);
            check("rnd_cout", carryout, e.cout);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
